// File: rtl/out_frame_fifo.sv
// Output framing stage: buffers accelerator pixels in a small FIFO, tags each
// pixel with end-of-line / end-of-frame on the sink side, and flags frame completion.
module out_frame_fifo #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_in,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_eol,
    output logic              out_eof,
    output logic              stop_out,
    output logic              busy
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(IMG_W * IMG_H - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [CNT_W-1:0]  r_in_cnt;
    logic [CNT_W-1:0]  r_out_cnt;
    logic [COL_W-1:0]  r_col;
    logic              r_stop;
    logic              r_busy;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Ready depends only on state and occupancy, so a pop in the same cycle
    // never opens a slot for a write (no fall-through path).
    assign in_ready  = (r_state == S_RUN) && !w_full;
    assign out_valid = !w_empty;
    assign out_data  = r_mem[r_rd_ptr];
    assign out_eol   = out_valid && (r_col == LAST_COL);
    assign out_eof   = out_valid && (r_out_cnt == LAST_PIX);
    assign stop_out  = r_stop;
    assign busy      = r_busy;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_col     <= '0;
            r_stop    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            if (w_push) begin
                r_in_cnt <= r_in_cnt + CNT_W'(1);
            end
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + CNT_W'(1);
                r_col     <= (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_in) begin
                        r_state   <= S_RUN;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_col     <= '0;
                        r_stop    <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_push && (r_in_cnt == LAST_PIX)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && (r_out_cnt == LAST_PIX)) begin
                        r_state <= S_DONE;
                        r_stop  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/out_frame_fifo.md
Name: out_frame_fifo

Overview:
- Synthesizable output stage between the blur accelerator's pixel output and the downstream stream sink.
- Frames one image of IMG_W x IMG_H 8-bit pixels, decoupling the two sides with a small FIFO under valid/ready handshakes.
- Tags each output pixel with end-of-line and end-of-frame.
- Raises stop_out, a level that tells the sink the frame is complete.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 256, pixels per line
- IMG_H, 256, lines per frame
- DEPTH, 8, FIFO entries; power of two, minimum 2
- CNT_W, 17, pixel counter width; must hold IMG_W*IMG_H

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
- start_in  in  1  frame start request, sampled each cycle
- in_data  in  DATA_W  pixel from accelerator
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  DATA_W  pixel to sink
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts this cycle
- out_eol  out  1  out_data is the last pixel of a line; qualified by out_valid
- out_eof  out  1  out_data is the last pixel of the frame; qualified by out_valid
- stop_out  out  1  frame fully delivered; level signal
- busy  out  1  state is RUN or DRAIN

Behaviour:
- Handshakes:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
  - in_ready is combinational from state and full only; it never depends on in_valid.
  - out_valid = !empty; it never depends on out_ready.
- Reset (reset==0 at an edge), also when taken mid-frame:
  - state=IDLE; FIFO flushed (pointers and count = 0); in_cnt=out_cnt=0; col=0.
  - Resulting outputs: stop_out=0, in_ready=0, out_valid=0, out_eol=0, out_eof=0, busy=0.
  - out_data is don't-care while out_valid=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=0. start_in=1 -> RUN; in_cnt, out_cnt and col are cleared.
  - RUN: in_ready = !full. Each input transfer writes the FIFO and increments in_cnt. When the transfer that brings in_cnt to IMG_W*IMG_H occurs -> DRAIN.
  - DRAIN: in_ready=0. Output transfers continue. When the output transfer that brings out_cnt to IMG_W*IMG_H occurs -> DONE.
  - DONE: stop_out=1, in_ready=0, FIFO empty. stop_out is held until start_in=1, which clears counters and goes -> RUN, with stop_out=0 from the next cycle.
  - start_in in RUN or DRAIN is ignored.
- FIFO:
  - Write pointer, read pointer and an occupancy count of width log2(DEPTH)+1.
  - full = (count==DEPTH); empty = (count==0).
  - out_data is a combinational read of mem[rd_ptr].
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - When full, in_ready=0 even if a pop occurs the same cycle; there is no fall-through.
- Latency: a pixel accepted at edge N is presented with out_valid=1 in the cycle after edge N, assuming the FIFO was empty. Throughput is 1 pixel/cycle with both sides streaming.
- Tags, computed on the output side:
  - col counts output transfers modulo IMG_W.
  - out_eol = out_valid && (col==IMG_W-1).
  - out_eof = out_valid && (out_cnt==IMG_W*IMG_H-1).
  - col and out_cnt advance only on output transfers.
- Boundaries:
  - Extra input pixels beyond the frame are never accepted; they remain pending on the input side.
  - The sink stalling indefinitely holds out_valid and out_data stable.
  - Counters never exceed IMG_W*IMG_H.

Test Plan:
1. Reset low 2 cycles, start_in pulse, out_ready=1, in_valid=1, feed in_data=i%256 for 65536 pixels:
   - output sequence identical to input;
   - first out_valid one cycle after first accept;
   - stop_out=1 the cycle after the 65536th output transfer; busy=0 then.
2. RUN with out_ready=0 and in_valid=1: exactly 8 inputs accepted, then in_ready=0. Raise out_ready: pixels 0..7 emerge in order and in_ready returns.
3. Random stalls on both sides (~50% in_valid, ~50% out_ready with runs of 1-8 cycles), full frame:
   - no loss or duplication;
   - out_eol on transfers 256, 512, ..., 65536;
   - out_eof only on transfer 65536.
4. in_valid held 1 after the 65536th accept: in_ready stays 0 in DRAIN and DONE; the 65537th pixel is never transferred. A start_in in DRAIN does not restart the frame.
5. Reset low after 1000 output transfers with 5 pixels in the FIFO:
   - next cycle out_valid=0, in_ready=0, stop_out=0;
   - a following start_in and a full frame yield exactly 65536 outputs, with out_eol first on transfer 256.
6. IMG_W=4, IMG_H=2, DEPTH=2: out_eol on transfers 4 and 8, out_eof on 8, stop_out set after it. A start_in in DONE runs a second 8-pixel frame with identical tagging.
